// File: rtl/unified_mem_pkg.sv
// Purpose : shared definitions for the unified line memory and the cache
//           modules that talk to it: FSM state and operation encodings,
//           default line/address widths and the latency counter width.
// Ports   : none (package).
package unified_mem_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_LINE_W = 64;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/unified_mem_if.sv
// Purpose : line-access handshake between the cache controller (master)
//           and the unified memory (slave).
// Signals : u_re/u_we   level requests, held until u_rdy
//           u_addr      line address
//           u_wdata     write line
//           u_rdy       one-cycle completion pulse
//           u_rdata     read line, held until the next read completes
//           u_busy      access in flight
interface unified_mem_if #(
  parameter int ADDR_W = unified_mem_pkg::DEF_ADDR_W,
  parameter int LINE_W = unified_mem_pkg::DEF_LINE_W
) ();

  logic              u_re;
  logic              u_we;
  logic [ADDR_W-1:0] u_addr;
  logic [LINE_W-1:0] u_wdata;
  logic              u_rdy;
  logic [LINE_W-1:0] u_rdata;
  logic              u_busy;

  modport master (
    output u_re, u_we, u_addr, u_wdata,
    input  u_rdy, u_rdata, u_busy
  );

  modport slave (
    input  u_re, u_we, u_addr, u_wdata,
    output u_rdy, u_rdata, u_busy
  );

endinterface

// File: rtl/unified_mem_array.sv
// Purpose : 2**ADDR_W x LINE_W line storage, synchronous write and
//           combinational read. Contents are never reset.
// Ports   : clk      clock, rising edge
//           i_we     write enable
//           i_waddr  write line address
//           i_wdata  write line
//           i_raddr  read line address
//           o_rdata  read line (combinational from i_raddr)
module unified_mem_array
  import unified_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [LINE_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [LINE_W-1:0] o_rdata
);

  logic [LINE_W-1:0] r_mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/unified_mem.sv
// Purpose : multi-cycle unified (instruction + data) line memory. Accepts
//           one line read or write from IDLE, completes it a fixed number
//           of cycles later with a single u_rdy pulse, then returns to IDLE.
// Ports   : clk    clock, rising edge
//           rst_n  asynchronous active-low reset; aborts any access
//           u_if   slave side of unified_mem_if (requests in, rdy/rdata/busy out)
module unified_mem
  import unified_mem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int LINE_W  = DEF_LINE_W,
  parameter int LATENCY = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  unified_mem_if.slave  u_if
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_range
    $error("unified_mem: LATENCY must be within 1..15");
  end

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;

  logic              w_req;
  logic              w_accept;
  logic              w_enter_done;
  logic              w_op_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [LINE_W-1:0] w_wdata;
  logic [LINE_W-1:0] w_mem_rdata;
  logic              w_mem_we;

  assign w_req = u_if.u_re | u_if.u_we;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_accept     = 1'b0;
    w_enter_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept  = 1'b1;
          w_cnt_nxt = LAT_M1;
          if (LATENCY == 1) begin
            w_state_nxt  = S_DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt  = S_DONE;
          w_enter_done = 1'b1;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // With LATENCY=1 the access completes on the accepting edge itself, so the
  // latches are not yet loaded: take operation/address/data from the bus.
  assign w_op_wr  = (r_state == S_IDLE) ? u_if.u_we    : (r_op == OP_WR);
  assign w_addr   = (r_state == S_IDLE) ? u_if.u_addr  : r_addr;
  assign w_wdata  = (r_state == S_IDLE) ? u_if.u_wdata : r_wdata;

  // Gated by rst_n so a request held during reset cannot commit a write.
  assign w_mem_we = w_enter_done & w_op_wr & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_op    <= OP_RD;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_op    <= u_if.u_we ? OP_WR : OP_RD;
        r_addr  <= u_if.u_addr;
        r_wdata <= u_if.u_wdata;
      end
      // A simultaneous read+write is a write, so rdata stays put.
      if (w_enter_done && !w_op_wr) r_rdata <= w_mem_rdata;
    end
  end

  unified_mem_array #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) u_mem_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_addr),
    .i_wdata (w_wdata),
    .i_raddr (w_addr),
    .o_rdata (w_mem_rdata)
  );

  assign u_if.u_rdy   = (r_state == S_DONE);
  assign u_if.u_busy  = (r_state != S_IDLE);
  assign u_if.u_rdata = r_rdata;

endmodule

// File: tb/tb_unified_mem.sv
// Directed bench for unified_mem: a LATENCY=4 instance for the main
// sequences and a LATENCY=1 instance for the single-cycle case.
module tb_unified_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  unified_mem_if #(.ADDR_W(14), .LINE_W(64)) if4 ();
  unified_mem_if #(.ADDR_W(14), .LINE_W(64)) if1 ();

  unified_mem #(.ADDR_W(14), .LINE_W(64), .LATENCY(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .u_if  (if4)
  );

  unified_mem #(.ADDR_W(14), .LINE_W(64), .LATENCY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .u_if  (if1)
  );

  localparam logic [63:0] D10   = 64'h1111_2222_3333_4444;
  localparam logic [63:0] D00   = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] D30   = 64'h3030_3030_3030_3030;
  localparam logic [63:0] D20   = 64'h2020_2020_2020_2020;
  localparam logic [63:0] D05   = 64'h0505_AAAA_5555_0505;
  localparam logic [63:0] DWR   = 64'hDEAD_BEEF_0000_0001;
  localparam logic [63:0] DA5   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] DFF   = 64'hFFFF_FFFF_FFFF_FFFF;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One access on the LATENCY=4 instance, starting from IDLE; requests are
  // dropped when u_rdy is seen and one extra edge returns the FSM to IDLE.
  task automatic access4(input logic re, input logic we, input logic [13:0] addr,
                         input logic [63:0] wd, output int rdy_at, output int n_pulses);
    if4.u_re    = re;
    if4.u_we    = we;
    if4.u_addr  = addr;
    if4.u_wdata = wd;
    rdy_at      = -1;
    n_pulses    = 0;
    for (int e = 0; e < 10 && rdy_at < 0; e++) begin
      tick();
      if (if4.u_rdy) begin
        rdy_at = e;
        n_pulses++;
        if4.u_re = 1'b0;
        if4.u_we = 1'b0;
      end
    end
    if4.u_re = 1'b0;
    if4.u_we = 1'b0;
    tick();
    if (if4.u_rdy) n_pulses++;
  endtask

  initial begin
    int          rdy_at;
    int          npl;
    logic [5:0]  rdy_h6;
    logic [5:0]  busy_h6;
    logic [9:0]  rdy_h10;
    logic [4:0]  rdy_h5;
    logic [4:0]  busy_h5;
    logic [63:0] cap_a;
    logic [63:0] cap_b;
    logic        seen;

    if4.u_re = 1'b0; if4.u_we = 1'b0; if4.u_addr = '0; if4.u_wdata = '0;
    if1.u_re = 1'b0; if1.u_we = 1'b0; if1.u_addr = '0; if1.u_wdata = '0;

    dut4.u_mem_array.r_mem[14'h0010] <= D10;
    dut4.u_mem_array.r_mem[14'h0000] <= D00;
    dut4.u_mem_array.r_mem[14'h0030] <= D30;
    dut4.u_mem_array.r_mem[14'h0020] <= D20;
    dut1.u_mem_array.r_mem[14'h0005] <= D05;

    // Reset state
    #12;
    chk("reset_rdy",   64'(if4.u_rdy),  64'd0);
    chk("reset_busy",  64'(if4.u_busy), 64'd0);
    chk("reset_rdata", if4.u_rdata,     64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // 1: read 0x0010, request raised before edge 0
    if4.u_re = 1'b1; if4.u_addr = 14'h0010;
    cap_a = '0;
    for (int e = 0; e < 6; e++) begin
      tick();
      rdy_h6[e]  = if4.u_rdy;
      busy_h6[e] = if4.u_busy;
      if (if4.u_rdy) begin
        cap_a    = if4.u_rdata;
        if4.u_re = 1'b0;
      end
    end
    if4.u_re = 1'b0;
    chk("t1_rdy_hist",   64'(rdy_h6),  64'b001000);
    chk("t1_busy_hist",  64'(busy_h6), 64'b001111);
    chk("t1_rdata",      cap_a,        D10);
    chk("t1_rdata_held", if4.u_rdata,  D10);

    // 2: write 0x3FFF, read it back, read 0x0000
    access4(1'b0, 1'b1, 14'h3FFF, DWR, rdy_at, npl);
    chk("t2_wr_latency",  64'(rdy_at), 64'd3);
    chk("t2_wr_rdata",    if4.u_rdata, D10);
    chk("t2_wr_array",    dut4.u_mem_array.r_mem[14'h3FFF], DWR);
    access4(1'b1, 1'b0, 14'h3FFF, '0, rdy_at, npl);
    chk("t2_rd_latency",  64'(rdy_at), 64'd3);
    chk("t2_rd_3fff",     if4.u_rdata, DWR);
    access4(1'b1, 1'b0, 14'h0000, '0, rdy_at, npl);
    chk("t2_rd_0000",     if4.u_rdata, D00);

    // 3: u_re held across two accesses, address changed while busy
    access4(1'b1, 1'b0, 14'h0010, '0, rdy_at, npl);
    if4.u_re = 1'b1; if4.u_addr = 14'h0010;
    cap_a = '0; cap_b = '0;
    for (int e = 0; e < 10; e++) begin
      tick();
      rdy_h10[e] = if4.u_rdy;
      if (if4.u_rdy && e < 5) cap_a = if4.u_rdata;
      if (if4.u_rdy && e >= 5) cap_b = if4.u_rdata;
      if (e == 0) if4.u_addr = 14'h0000;
      if (e == 5) if4.u_addr = 14'h3FFF;
    end
    if4.u_re = 1'b0;
    tick();
    chk("t3_rdy_hist", 64'(rdy_h10), 64'b01_0000_1000);
    chk("t3_rdata_1",  cap_a,        D10);
    chk("t3_rdata_2",  cap_b,        D00);

    // 4: read+write together -> write wins, rdata untouched
    access4(1'b1, 1'b1, 14'h0020, DA5, rdy_at, npl);
    chk("t4_pulses", 64'(npl),    64'd1);
    chk("t4_rdata",  if4.u_rdata, D00);
    chk("t4_array",  dut4.u_mem_array.r_mem[14'h0020], DA5);

    // 5: reset in the middle of a write
    if4.u_we = 1'b1; if4.u_addr = 14'h0030; if4.u_wdata = DFF;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t5_busy_now", 64'(if4.u_busy), 64'd0);
    chk("t5_rdy_now",  64'(if4.u_rdy),  64'd0);
    if4.u_we = 1'b0;
    seen = 1'b0;
    repeat (3) begin tick(); seen |= if4.u_rdy; end
    rst_n = 1'b1;
    repeat (6) begin tick(); seen |= if4.u_rdy; end
    chk("t5_no_rdy", 64'(seen),    64'd0);
    chk("t5_array",  dut4.u_mem_array.r_mem[14'h0030], D30);
    chk("t5_rdata",  if4.u_rdata, 64'd0);

    // 6: LATENCY=1, u_re held -> completes every other cycle
    if1.u_re = 1'b1; if1.u_addr = 14'h0005;
    cap_a = '0;
    for (int e = 0; e < 5; e++) begin
      tick();
      rdy_h5[e]  = if1.u_rdy;
      busy_h5[e] = if1.u_busy;
      if (if1.u_rdy && e == 0) cap_a = if1.u_rdata;
    end
    if1.u_re = 1'b0;
    tick();
    chk("t6_rdy_hist",  64'(rdy_h5),  64'b10101);
    chk("t6_busy_hist", 64'(busy_h5), 64'b10101);
    chk("t6_rdata",     cap_a,        D05);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
